// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display driver:
// active-low segment patterns, the segment decoder and the converter FSM states.
package ssd_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } convState_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// result published to bcd only once all WIDTH iterations have finished.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic [15:0]      bcd
);

    localparam int SRW = WIDTH + 16;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    convState_t     state;
    logic [SRW-1:0] shiftReg;
    logic [SRW-1:0] stepReg;
    logic [CW-1:0]  iterCnt;

    // One iteration: correct every BCD nibble that would overflow past 9, then shift.
    always_comb begin
        stepReg = shiftReg;
        for (int k = 0; k < 4; k++) begin
            if (stepReg[WIDTH + 4*k +: 4] >= 4'd5)
                stepReg[WIDTH + 4*k +: 4] = stepReg[WIDTH + 4*k +: 4] + 4'd3;
        end
        stepReg = stepReg << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bcd      <= '0;
            shiftReg <= '0;
            iterCnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shiftReg <= {16'h0000, bin};
                        iterCnt  <= '0;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    shiftReg <= stepReg;
                    iterCnt  <= iterCnt + CW'(1);
                    if (iterCnt == LAST_ITER) begin
                        bcd   <= stepReg[SRW-1:WIDTH];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ssd_driver.sv
// Four-digit multiplexed seven-segment driver: converts the debug value to BCD
// on change and scans the digits with optional leading-zero blanking.
module ssd_driver
    import ssd_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int REFRESH_DIV = 50000,
    parameter bit LZB         = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       anode,
    output logic [6:0]       cathode,
    output logic             dp,
    output logic [15:0]      bcd,
    output logic             busy
);

    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

    logic [WIDTH-1:0] shadow;
    logic             start;
    logic [15:0]      refreshCnt;
    logic [1:0]       digitIdx;
    logic [3:0]       nibble;
    logic             blank;

    assign dp = 1'b1;

    // busy low means the converter is idle, so a changed value can be taken now.
    assign start = !busy && (value != shadow);

    bin2bcd_seq #(
        .WIDTH(WIDTH)
    ) uConv (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .bin  (value),
        .busy (busy),
        .bcd  (bcd)
    );

    always_comb begin
        nibble = bcd[3:0];
        blank  = 1'b0;
        case (digitIdx)
            2'd1: begin
                nibble = bcd[7:4];
                blank  = (bcd[15:4] == 12'h000);
            end
            2'd2: begin
                nibble = bcd[11:8];
                blank  = (bcd[15:8] == 8'h00);
            end
            2'd3: begin
                nibble = bcd[15:12];
                blank  = (bcd[15:12] == 4'h0);
            end
            default: ;
        endcase
        if (!LZB)
            blank = 1'b0;
    end

    // Scan counter and registered pin drivers share one block so they stay in lockstep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow     <= '0;
            refreshCnt <= '0;
            digitIdx   <= '0;
            anode      <= 4'b1111;
            cathode    <= SEG_OFF;
        end else begin
            if (start)
                shadow <= value;
            if (refreshCnt == REFRESH_LAST) begin
                refreshCnt <= '0;
                digitIdx   <= digitIdx + 2'd1;
            end else begin
                refreshCnt <= refreshCnt + 16'd1;
            end
            if (blank) begin
                anode   <= 4'b1111;
                cathode <= SEG_OFF;
            end else begin
                anode   <= ~(4'b0001 << digitIdx);
                cathode <= seg_decode(nibble);
            end
        end
    end

endmodule

// File: tb/tb_ssd_driver.sv
// Scoreboard bench for ssd_driver: expected BCD results are queued on stimulus and
// popped by a monitor at each conversion completion; display scans are checked per slot.
module tb_ssd_driver;

    localparam logic [6:0] OFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] value = 13'd0;

    logic [3:0]  anodeA, anodeB;
    logic [6:0]  cathodeA, cathodeB;
    logic        dpA, dpB;
    logic [15:0] bcdA, bcdB;
    logic        busyA, busyB;

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;
    logic [15:0] expQ[$];

    always #5 clk = ~clk;

    ssd_driver #(.WIDTH(13), .REFRESH_DIV(4), .LZB(1'b1)) dutA (
        .clk(clk), .rst(rst), .value(value), .anode(anodeA), .cathode(cathodeA),
        .dp(dpA), .bcd(bcdA), .busy(busyA)
    );

    ssd_driver #(.WIDTH(13), .REFRESH_DIV(4), .LZB(1'b0)) dutB (
        .clk(clk), .rst(rst), .value(value), .anode(anodeB), .cathode(cathodeB),
        .dp(dpB), .bcd(bcdB), .busy(busyB)
    );

    // Edges since reset release; sets the expected scan slot independent of the DUT.
    always @(posedge clk) begin
        if (!rst) edgeCnt <= 0;
        else      edgeCnt <= edgeCnt + 1;
    end

    // Monitor: a falling busy is a completed conversion; bcd may change only then.
    logic        busyPrev = 1'b0;
    logic [15:0] bcdPrev = 16'h0000;
    int          busyCycles = 0;
    always @(negedge clk) begin
        logic [15:0] expBcd;
        if (!rst) begin
            busyPrev   = 1'b0;
            bcdPrev    = bcdA;
            busyCycles = 0;
        end else begin
            if (busyPrev && !busyA) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedDone actual bcd=%h required no conversion", bcdA);
                end else begin
                    expBcd = expQ.pop_front();
                    if (bcdA !== expBcd) begin
                        errors++;
                        $display("[TB] FAIL bcdResult actual %h required %h", bcdA, expBcd);
                    end
                end
                checks++;
                if (busyCycles != 13) begin
                    errors++;
                    $display("[TB] FAIL busyWidth actual %0d required 13", busyCycles);
                end
                busyCycles = 0;
            end else begin
                checks++;
                if (bcdA !== bcdPrev) begin
                    errors++;
                    $display("[TB] FAIL bcdStable actual %h required %h", bcdA, bcdPrev);
                end
            end
            if (busyA) busyCycles++;
            busyPrev = busyA;
            bcdPrev  = bcdA;
        end
    end

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Change value one edge after the current one; busy must be up at the returning negedge.
    task automatic applyStimulus(input logic [12:0] v, input logic [15:0] expBcd);
        @(posedge clk);
        #1;
        value = v;
        expQ.push_back(expBcd);
        @(posedge clk);
        @(negedge clk);
        checkVal("busyRise", {15'd0, busyA}, 16'd1);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busyA && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busyA) begin
            errors++;
            $display("[TB] FAIL %s timeout actual busy=1 required busy=0", name);
        end
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain actual %0d pending required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Each sample is compared against the slot the scan should be on at that edge.
    task automatic checkOutput(input string name, input bit useB,
                               input logic [15:0] expAn, input logic [27:0] expCat);
        int slot;
        logic [3:0] an;
        logic [6:0] cat;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            slot = ((edgeCnt - 1) / 4) % 4;
            an   = useB ? anodeB : anodeA;
            cat  = useB ? cathodeB : cathodeA;
            checks++;
            if (an !== expAn[4*slot +: 4] || cat !== expCat[7*slot +: 7]) begin
                errors++;
                $display("[TB] FAIL %s slot%0d actual anode=%b cathode=%b required anode=%b cathode=%b",
                         name, slot, an, cat, expAn[4*slot +: 4], expCat[7*slot +: 7]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int busySeen;

        // Reset held with a nonzero value on the input
        rst   = 1'b0;
        value = 13'd1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rstAnode", {12'd0, anodeA}, 16'h000F);
        checkVal("rstCathode", {9'd0, cathodeA}, 16'h007F);
        checkVal("rstBcd", bcdA, 16'h0000);
        checkVal("rstBusy", {15'd0, busyA}, 16'd0);
        checkVal("dpOff", {15'd0, dpA}, 16'd1);
        expQ.push_back(16'h1234);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkVal("busyFirstEdge", {15'd0, busyA}, 16'd1);
        waitIdle("conv1234");
        checkOutput("disp1234", 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

        // Full-scale value
        applyStimulus(13'd8191, 16'h8191);
        waitIdle("conv8191");
        checkOutput("disp8191", 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0000000, 7'b1111001, 7'b0010000, 7'b1111001});

        // Leading-zero blanking against the unblanked instance
        applyStimulus(13'd7, 16'h0007);
        waitIdle("conv7");
        checkOutput("lzb7", 1'b0, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {OFF, OFF, OFF, 7'b1111000});
        checkOutput("noLzb7", 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000});
        applyStimulus(13'd0, 16'h0000);
        waitIdle("conv0");
        checkOutput("lzb0", 1'b0, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {OFF, OFF, OFF, 7'b1000000});
        applyStimulus(13'd105, 16'h0105);
        waitIdle("conv105");
        checkOutput("lzb105", 1'b0, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    {OFF, 7'b1111001, 7'b1000000, 7'b0010010});

        // Value change while converting: finishes 100, then one idle cycle, then 200
        applyStimulus(13'd100, 16'h0100);
        repeat (3) @(posedge clk);
        #1;
        value = 13'd200;
        expQ.push_back(16'h0200);
        @(negedge clk);
        n = 0;
        while (busyA && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkVal("gapLow", {15'd0, busyA}, 16'd0);
        @(negedge clk);
        checkVal("gapOneCycle", {15'd0, busyA}, 16'd1);
        waitIdle("conv200");

        // Reset landing on the sixth iteration aborts, then the conversion restarts
        applyStimulus(13'd4095, 16'h4095);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("abortBcd", bcdA, 16'h0000);
        checkVal("abortBusy", {15'd0, busyA}, 16'd0);
        checkVal("abortAnode", {12'd0, anodeA}, 16'h000F);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkVal("restartBusy", {15'd0, busyA}, 16'd1);
        waitIdle("conv4095");

        // Stable value: no further conversions
        applyStimulus(13'd42, 16'h0042);
        waitIdle("conv42");
        busySeen = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (busyA) busySeen++;
        end
        checkVal("stableBusy", 16'(busySeen), 16'd0);
        checkVal("stableBcd", bcdA, 16'h0042);
        checkVal("bcdB", bcdB, 16'h0042);
        checkVal("busyB", {15'd0, busyB}, 16'd0);
        checkVal("dpB", {15'd0, dpB}, 16'd1);
        checkOutput("disp42", 1'b0, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    {OFF, OFF, 7'b0011001, 7'b0100100});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_driver.md
Name: ssd_driver

Overview:
Drives the 4-digit multiplexed seven-segment display from the CPU's 13-bit SSD debug value (PC, register data, ALU result, etc.).
Converts the binary value to BCD with a sequential double-dabble engine. Refreshes the four digits in time-multiplexed fashion and applies leading-zero blanking.
Sits at board top level, between the CPU's SSD output and the FPGA anode/cathode pins.

Parameters:
WIDTH, 13, binary input width; must be 13 or less, since 8191 fits in 4 BCD digits
REFRESH_DIV, 50000, clk cycles each digit stays lit; legal range 1..65535
LZB, 1, 1 = blank leading zero digits; 0 = always show all 4 digits

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-low reset
value  in  WIDTH  binary value to display
anode  out  4  digit enables, active-low; anode[0] = least-significant digit
cathode  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low; tied to 1 (off)
bcd  out  16  last completed conversion; 4 nibbles, nibble 0 = ones digit
busy  out  1  high while a conversion is in progress

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-low. All state updates on the rising edge of clk.
- Reset values while rst=0: anode=4'b1111, cathode=7'b1111111, bcd=16'h0000, busy=0, shadow=0, refresh counter=0, digit index=0, FSM=IDLE.
- Reset asserted mid-conversion aborts the conversion. bcd returns to 0.
- Conversion FSM states: IDLE and CONVERT.
- IDLE: on any edge where value != shadow, the FSM:
  - sets shadow<=value;
  - loads the shift register as {16'h0, value};
  - clears the iteration counter;
  - sets busy<=1 and moves to CONVERT.
- CONVERT, each edge performs one iteration:
  - add 3 to every BCD nibble that is >=5;
  - then shift the whole register left by 1;
  - increment the iteration counter.
- On the WIDTH-th CONVERT edge: bcd<=final BCD nibbles, busy<=0, return to IDLE.
- Latency and timing: busy is high for exactly WIDTH cycles. bcd updates WIDTH edges after the capture edge. bcd never shows partial results.
- value is ignored during CONVERT. If value differs from shadow once back in IDLE, a new conversion starts on the next edge; the intermediate value is dropped. Back-to-back conversions need no idle gap beyond that one IDLE cycle.
- Refresh counter:
  - counts 0..REFRESH_DIV-1;
  - on wrap, digit index advances 0→1→2→3→0;
  - with REFRESH_DIV=1 the index advances every cycle.
- anode and cathode are registered. They reflect the current index and bcd one cycle later.
- Digit index i selects bcd[4i+3:4i]:
  - anode = ~(4'b0001<<i);
  - cathode = segment decode of that nibble.
- Segment decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10..15 show dash 0111111 (unreachable in normal use).
- Leading-zero blanking (LZB=1): digit i>0 is blanked if its nibble and all higher nibbles are zero. A blanked digit drives anode=4'b1111 and cathode=7'b1111111. Digit 0 is never blanked, so value 0 shows "0".
- The display shows the old bcd until a conversion completes; there is no flicker on change.

Decomposition:
- ssd_pkg holds:
  - segment localparams SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - function seg_decode(nibble)->7 bits;
  - FSM state encoding (IDLE=1'b0, CONVERT=1'b1).
- One sub-module: bin2bcd_seq.
  - Contains the double-dabble datapath, iteration counter and FSM.
  - Ports: clk, rst, start, bin, busy, bcd.
- ssd_driver contains the change detect, refresh counter, digit mux, blanking and output registers.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with value=13'd1234 → anode=1111, cathode=1111111, bcd=0000, busy=0. After release: busy rises on the 1st edge, bcd=16'h1234 exactly 13 edges later.
2. value=8191, REFRESH_DIV=4 → bcd=16'h8191. anode cycles 1110,1101,1011,0111, each held 4 cycles, with cathode 1111001, 0010000, 1111001, 0000000 respectively.
3. LZB=1: value=7 → digit0 shows 1111000, slots 1–3 show anode=1111. value=0 → digit0 shows 1000000. value=105 → digits 0,1,2 shown (1 0 5), digit3 blanked. LZB=0 with value=7 → all 4 anodes active, showing "0007".
4. Mid-conversion change: value 100, then 200 three cycles later → bcd goes 0000→0100 (no other intermediate value) → 0200. busy drops for exactly one cycle between the two conversions.
5. Reset mid-conversion: value=4095, assert rst at CONVERT iteration 6 → bcd=0, busy=0. After release, conversion restarts and bcd=16'h4095.
6. Stable value: hold 42 for 1000 cycles → busy stays 0 after the first conversion, and bcd=16'h0042 is constant.
